// File: rtl/way_allocator.sv
// Per-set true-LRU way allocator: hit/miss lookup with one-cycle registered response and line invalidate.
// Define VICTIM_INVALID_FIRST_EN to prefer the lowest-numbered invalid way as the miss victim.
module way_allocator #(
    parameter int i_size = 14,
    parameter int c_size = 10,
    parameter int d_size = 6,
    parameter int a_size = 4,
    localparam int WW = $clog2(a_size),
    localparam int IW = c_size - d_size - WW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic [IW-1:0] req_index,
    input  logic          req_hit,
    input  logic [WW-1:0] req_way,
    input  logic          inv_valid,
    input  logic [IW-1:0] inv_index,
    input  logic [WW-1:0] inv_way,
    output logic          resp_valid,
    output logic [WW-1:0] resp_way,
    output logic          resp_evict
);

    localparam int n_sets = 2 ** IW;
    localparam logic [WW-1:0] lru_age = WW'(a_size - 1);

    if (a_size < 2 || (a_size & (a_size - 1)) != 0) begin : g_bad_assoc
        $error("way_allocator: a_size must be a power of two >= 2");
    end
    if (i_size < c_size) begin : g_bad_addr
        $error("way_allocator: address narrower than cache capacity");
    end

    logic [a_size-1:0]          valid_q [n_sets];
    logic [a_size-1:0][WW-1:0]  age_q   [n_sets];

    logic [a_size-1:0]          set_valid;
    logic [a_size-1:0][WW-1:0]  set_age;
    logic [a_size-1:0][WW-1:0]  next_age;
    logic [WW-1:0]              lru_way;
    logic [WW-1:0]              victim;
    logic [WW-1:0]              use_way;
    logic [WW-1:0]              use_age;

    always_comb begin
        set_valid = valid_q[req_index];
        set_age   = age_q[req_index];

        lru_way = '0;
        for (int w = 0; w < a_size; w++) begin
            if (set_age[w] == lru_age) lru_way = WW'(w);
        end

        victim = lru_way;
`ifdef VICTIM_INVALID_FIRST_EN
        // Walk downward so the lowest-numbered invalid way is the last writer.
        for (int w = a_size - 1; w >= 0; w--) begin
            if (!set_valid[w]) victim = WW'(w);
        end
`endif

        use_way = req_hit ? req_way : victim;
        use_age = set_age[use_way];

        for (int w = 0; w < a_size; w++) begin
            if (WW'(w) == use_way)
                next_age[w] = '0;
            else if (set_age[w] < use_age)
                next_age[w] = set_age[w] + WW'(1);
            else
                next_age[w] = set_age[w];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_way   <= '0;
            resp_evict <= 1'b0;
            // NOTE: the state arrays are tiny and must start as defined LRU permutations, so they are reset explicitly.
            for (int s = 0; s < n_sets; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < a_size; w++) age_q[s][w] <= WW'(a_size - 1 - w);
            end
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                resp_way   <= use_way;
                resp_evict <= !req_hit && set_valid[use_way];
                age_q[req_index] <= next_age;
                if (!req_hit) valid_q[req_index][use_way] <= 1'b1;
            end
            // NOTE: non-blocking updates take the last write, so an invalidate of the same line overrides the allocation.
            if (inv_valid) valid_q[inv_index][inv_way] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_way_allocator.sv
// Directed and model-checked random stimulus for way_allocator with the default parameters (4 sets x 4 ways).
module tb_way_allocator;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_index;
    logic       req_hit;
    logic [1:0] req_way;
    logic       inv_valid;
    logic [1:0] inv_index;
    logic [1:0] inv_way;
    logic       resp_valid;
    logic [1:0] resp_way;
    logic       resp_evict;

    way_allocator dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_index  (req_index),
        .req_hit    (req_hit),
        .req_way    (req_way),
        .inv_valid  (inv_valid),
        .inv_index  (inv_index),
        .inv_way    (inv_way),
        .resp_valid (resp_valid),
        .resp_way   (resp_way),
        .resp_evict (resp_evict)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    int   m_age   [4][4];
    bit   m_valid [4][4];
    logic [1:0] exp_way;
    logic       exp_evict;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++) begin
                m_age[s][w]   = 3 - w;
                m_valid[s][w] = 1'b0;
            end
    endtask

    // One clock: drive inputs, predict from the model's pre-edge state, check after the edge.
    task automatic do_cycle(input logic r, input logic rv, input logic [1:0] idx,
                            input logic hit, input logic [1:0] way,
                            input logic iv, input logic [1:0] iidx, input logic [1:0] iway);
        int  vic;
        int  old;
        bit  found;
        rst = r; req_valid = rv; req_index = idx; req_hit = hit; req_way = way;
        inv_valid = iv; inv_index = iidx; inv_way = iway;
        if (r) begin
            model_reset();
            exp_way = 2'd0;
            exp_evict = 1'b0;
        end else begin
            if (rv) begin
                if (hit) begin
                    vic = way;
                end else begin
                    vic = 0;
                    for (int w = 0; w < 4; w++) if (m_age[idx][w] == 3) vic = w;
`ifdef VICTIM_INVALID_FIRST_EN
                    found = 1'b0;
                    for (int w = 0; w < 4; w++)
                        if (!found && !m_valid[idx][w]) begin vic = w; found = 1'b1; end
`endif
                end
                exp_way   = 2'(vic);
                exp_evict = !hit && m_valid[idx][vic];
                old = m_age[idx][vic];
                for (int w = 0; w < 4; w++) if (m_age[idx][w] < old) m_age[idx][w]++;
                m_age[idx][vic] = 0;
                if (!hit) m_valid[idx][vic] = 1'b1;
            end
            if (iv) m_valid[iidx][iway] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("resp_valid", resp_valid, !r && rv);
        if (r || rv) begin
            check("resp_way", resp_way, exp_way);
            check("resp_evict", resp_evict, exp_evict);
        end
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic miss(input logic [1:0] idx);
        do_cycle(1'b0, 1'b1, idx, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic check_state();
        logic [3:0] mask;
        for (int s = 0; s < 4; s++) begin
            mask = '0;
            for (int w = 0; w < 4; w++) begin
                mask[dut.age_q[s][w]] = 1'b1;
                check("age_vs_model", dut.age_q[s][w], m_age[s][w]);
                check("valid_vs_model", dut.valid_q[s][w], m_valid[s][w]);
            end
            check("age_perm", mask, 4'hf);
        end
    endtask

    task automatic check_reset_ages(input string tag);
        for (int s = 0; s < 4; s++)
            for (int w = 0; w < 4; w++) begin
                check(tag, dut.age_q[s][w], 3 - w);
                check({tag, "_valid"}, dut.valid_q[s][w], 0);
            end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] ages_exp [4];
        logic [1:0] ridx;
        logic [1:0] rway;
        logic       rhit;
        rst = 1'b1; req_valid = 1'b0; req_index = '0; req_hit = 1'b0; req_way = '0;
        inv_valid = 1'b0; inv_index = '0; inv_way = '0;
        model_reset();

        // Reset with a request and invalidate presented: both discarded.
        do_cycle(1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0);
        do_cycle(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
        check_reset_ages("reset_age");

        // Four misses to set 0 allocate ways 0..3 without eviction.
        for (int i = 0; i < 4; i++) begin
            miss(2'd0);
            check("fill_way", resp_way, i);
            check("fill_evict", resp_evict, 0);
            check("fill_latency", resp_valid, 1);
        end
        idle();
        check("idle_no_resp", resp_valid, 0);

        // Hit way 0, then miss evicts way 1.
        do_cycle(1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0);
        check("hit_way", resp_way, 0);
        check("hit_evict", resp_evict, 0);
        miss(2'd0);
        check("lru_miss_way", resp_way, 1);
        check("lru_miss_evict", resp_evict, 1);
        ages_exp = '{2'd1, 2'd0, 2'd3, 2'd2};
        for (int w = 0; w < 4; w++) check("ages_after_hit_miss", dut.age_q[0][w], ages_exp[w]);

        // Invalidate way 2 (currently LRU), then miss: way 2 in either build, no eviction.
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd2);
        check("inv_no_resp", resp_valid, 0);
        miss(2'd0);
        check("inv_lru_way", resp_way, 2);
        check("inv_lru_evict", resp_evict, 0);

        // Invalidate way 0 (age 2, not LRU): only the invalid-first build reuses it.
        do_cycle(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0);
        miss(2'd0);
`ifdef VICTIM_INVALID_FIRST_EN
        check("inv_mid_way", resp_way, 0);
        check("inv_mid_evict", resp_evict, 0);
`else
        check("inv_mid_way", resp_way, 3);
        check("inv_mid_evict", resp_evict, 1);
        check("inv_mid_valid0", dut.valid_q[0][0], 0);
`endif

        // Fill set 3, then miss with a same-cycle invalidate of the victim (way 0).
        for (int i = 0; i < 4; i++) miss(2'd3);
        do_cycle(1'b0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 2'd3, 2'd0);
        check("same_set_way", resp_way, 0);
        check("same_set_evict", resp_evict, 1);
        check("same_set_valid", dut.valid_q[3][0], 0);

        // Miss to set 1 alongside invalidate of set 3 way 1: independent.
        do_cycle(1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b1, 2'd3, 2'd1);
        check("diff_set_way", resp_way, 0);
        check("diff_set_evict", resp_evict, 0);
        check("diff_set_inv", dut.valid_q[3][1], 0);
        check_state();

        // Request, then reset on the following edge drops the response.
        miss(2'd2);
        check("pre_reset_resp", resp_valid, 1);
        do_cycle(1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
        check("reset_drop_resp", resp_valid, 0);
        check_reset_ages("midreset_age");
        for (int i = 0; i < 4; i++) begin
            miss(2'd1);
            check("post_reset_way", resp_way, i);
            check("post_reset_evict", resp_evict, 0);
        end

        // Random stream against the model.
        for (int i = 0; i < 400; i++) begin
            ridx = 2'($urandom_range(0, 3));
            rway = 2'($urandom_range(0, 3));
            rhit = m_valid[ridx][rway] && ($urandom_range(0, 1) == 1);
            do_cycle(1'b0, ($urandom_range(0, 3) != 0), ridx, rhit, rway,
                     ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            check_state();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/way_allocator.md
WAY_ALLOCATOR -- requirements
Module: way_allocator

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- i_size, 14, address width in bits.
- c_size, 10, log2 of cache capacity in bytes.
- d_size, 6, log2 of line size in bytes.
- a_size, 4, associativity in ways; power of two, at least 2.
REQ-002 Derived widths: IW = c_size - d_size - $clog2(a_size) is the set-index width; WW = $clog2(a_size) is the way width. Number of sets is 2**IW.
REQ-003 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, the only clock; all state changes on the rising edge.
- rst, in, 1, synchronous reset, active high.
- req_valid, in, 1, lookup result is presented this cycle.
- req_index, in, IW, set index.
- req_hit, in, 1, the tag matched a way.
- req_way, in, WW, matching way; ignored when req_hit=0.
- inv_valid, in, 1, invalidate one line.
- inv_index, in, IW, set to invalidate.
- inv_way, in, WW, way to invalidate.
- resp_valid, out, 1, response is valid.
- resp_way, out, WW, way that was used: the hit way or the allocated way.
- resp_evict, out, 1, the allocated way held a valid line.

Function
REQ-004 State per set: valid[w] and age[w], where age is WW bits; age 0 is the most recently used way (MRU) and age a_size-1 is the least recently used way (LRU).
REQ-005 Within each set, the age values always form a permutation of 0..a_size-1.
REQ-006 Requests are accepted every cycle; there is no backpressure.
REQ-007 Latency is 1 cycle: resp_* are registered and are valid on the edge after req_valid. resp_valid=0 in any cycle that follows a cycle with req_valid=0.
REQ-008 Hit: resp_way=req_way and resp_evict=0; way req_way is touched.
REQ-009 Miss: the victim is selected per REQ-015 and REQ-016. resp_way=victim; resp_evict is the pre-update valid[victim]; valid[victim] is set to 1; the victim is touched.
REQ-010 Touch of way x with old age a: every way in the set with age < a increments by 1, x takes age 0, and all other ages are unchanged. Touching the current MRU changes nothing.
REQ-011 Invalidate: clears valid[inv_way] in set inv_index; ages are unchanged; there is no response.
REQ-012 Simultaneous request and invalidate to the same set: the request is evaluated against the pre-edge state, then the invalidate is applied. If both target the same way, the final valid bit is 0, and resp_evict still reflects the pre-edge valid bit.
REQ-013 Simultaneous request and invalidate to different sets: the two operations are independent.
REQ-014 Back-to-back requests to the same set: each request observes the state left by the previous edge. There is no stale read.

Reset
REQ-017 While rst=1 at an edge: resp_valid=0, resp_way=0, resp_evict=0; every valid bit is cleared; age[w] = a_size-1-w in every set.
REQ-018 Requests and invalidates presented in the same cycle as rst=1 are discarded.
REQ-019 Reset asserted mid-stream drops the pending response: resp_valid is 0 on the next edge.

Configuration
REQ-015 With VICTIM_INVALID_FIRST_EN defined: the miss victim is the lowest-numbered way with valid=0. If all ways are valid, the victim is the way with age a_size-1.
REQ-016 Without VICTIM_INVALID_FIRST_EN: the victim is always the way with age a_size-1, regardless of valid bits.

Verification
REQ-020 Reset, then 4 misses to set 0 -> resp_way is 0, 1, 2, 3 in order; resp_evict=0 on every response; each response 1 cycle after its request.
REQ-021 After REQ-020: hit on way 0, then a miss to set 0 -> the miss gives resp_way=1 and resp_evict=1; ages in set 0 end as way1=0, way0=1, way3=2, way2=3.
REQ-022 Set 0 full; invalidate way 2; then a miss to set 0 -> with the macro, resp_way=2 and resp_evict=0; without the macro, resp_way is the LRU way and resp_evict matches that way's pre-edge valid bit.
REQ-023 Same-cycle miss and invalidate to the same set, invalidate targeting the victim way -> resp_evict is the pre-edge valid bit; valid[victim] ends 0.
REQ-024 Request issued, then rst asserted the next cycle -> resp_valid=0 after that edge; all sets return to the reset ages; the next 4 misses to set 1 allocate ways 0, 1, 2, 3.
REQ-025 Random request/invalidate stream checked against a reference model -> every set's ages remain a permutation, and every response matches the model.
